uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: deserialises an asynchronous serial line (ESP32 or PC side) into bytes for the transmit stage.
- Frame format is fixed: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the data bits), 1 stop bit (1). This matches the transmitter's framing.
- Outputs the byte on `data_o`, with a one-cycle `receive_ack` pulse that directly triggers the downstream transmitter's send.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); must be >= 8.
- CNT_W, $clog2(CLKS_PER_BIT), baud counter width (derived; do not override).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rxd  input  1  serial line, idle high, asynchronous to clk
- data_o  output  8  last correctly received byte; held until the next good byte
- receive_ack  output  1  one-cycle pulse: new good byte on data_o
- parity_err  output  1  one-cycle pulse: parity mismatch, byte discarded
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, active-high):
  - state = IDLE; data_o = 8'h00; receive_ack, parity_err, frame_err = 0.
  - Both synchroniser flops set to 1; all counters = 0.
- Synchroniser: rxd passes through 2 flops to give rxd_s; all logic uses rxd_s only.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a falling edge on rxd_s (previous 1, current 0) clears baud_cnt and moves to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample.
    - Sample 0: go to DATA with baud_cnt = 0 and bit_idx = 0.
    - Sample 1: false start (glitch); return to IDLE with no outputs.
  - DATA: every CLKS_PER_BIT cycles, sample into shift[bit_idx] (LSB first).
    - bit_idx increments after each sample.
    - After the sample with bit_idx == 7, go to PARITY.
  - PARITY: after CLKS_PER_BIT cycles, store par_bit, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - Sample 1 and par_bit == ^shift: data_o <= shift, receive_ack pulses 1 cycle, go to IDLE.
    - Sample 1 and parity mismatch: parity_err pulses 1 cycle, data_o unchanged, go to IDLE.
    - Sample 0: frame_err pulses 1 cycle, data_o unchanged, parity is not evaluated, go to BREAK.
  - BREAK: stay until rxd_s == 1, then go to IDLE. This stops a held-low line from retriggering reception.
- Sample timing:
  - Bit k is sampled (k + 0.5) * CLKS_PER_BIT cycles after the falling edge of rxd_s. Start bit is k = 0; stop bit is k = 10.
  - The output pulse is registered and asserts 1 cycle after the stop sample.
  - Total latency from the rxd start edge to receive_ack is 10.5 * CLKS_PER_BIT + 3 cycles, ±1.
- Arithmetic:
  - baud_cnt is CNT_W bits wide and counts 0..CLKS_PER_BIT-1, then wraps; the sample point is the wrap.
  - bit_idx is 3 bits wide.
- Back-to-back frames: a start edge may arrive in the first cycle after the STOP sample and must be caught. There is no minimum idle gap.
- Pulse exclusivity: receive_ack, parity_err and frame_err are mutually exclusive, and each is at most 1 cycle per frame.
- Reset mid-frame: returns to IDLE immediately; the partial byte is discarded and no pulse is generated.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every sample (start check, data, parity, stop) is a 2-of-3 majority vote.
  - The three reads are rxd_s at sample point −1, sample point, and sample point +1 cycle.
  - Decision timing is unchanged; the result is used at sample point +1.
  - Latency grows by 1 cycle.
- Undefined: a single read at the sample point.

Decomposition:
- Package uart_pkg:
  - State enum, shared with the transmitter's encoding style.
  - Localparams DATA_BITS = 8, PARITY_EVEN = 1, and the default CLKS_PER_BIT.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset value 1. It is reusable for other async inputs (e.g. buttons).
- The rest stays in one module.

Test Plan (CLKS_PER_BIT = 16; Test 3 is run both with and without UART_RX_MAJORITY_EN):
1. Send 0xA5 with parity 0 and stop 1 → data_o = 8'hA5, receive_ack high for exactly 1 cycle about 171 cycles after the start edge, no error pulses.
2. Send 0x01 with parity 0 (correct value is 1) → parity_err pulses once, receive_ack stays 0, data_o keeps its previous value (0xA5).
3. Start-bit glitch and single-cycle spike:
   - rxd low for 5 cycles, then high → no outputs, busy returns to 0, state returns to IDLE.
   - With UART_RX_MAJORITY_EN, a 1-cycle spike in the middle of data bit 3 of 0x00 still gives data_o = 0x00.
   - Without the macro, the same stimulus gives parity_err.
4. Send 0x3C with stop bit 0, then hold rxd low for 40 bit times → exactly one frame_err pulse, state held in BREAK. After rxd goes high, a following 0x7E is received correctly.
5. Send 0x00 then 0xFF back-to-back with zero idle gap → two receive_ack pulses, data_o = 0x00 then 0xFF.
6. Assert rst during data bit 4 → outputs go to reset values immediately. The next full 0x5A frame after release is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and framing constants.
package uart_pkg;

   localparam int DATA_BITS        = 8;
   localparam bit PARITY_EVEN      = 1'b1;
   localparam int CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200 baud

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 (idle-high lines, buttons).
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         // NOTE: non-blocking so both flops sample their inputs from the same edge.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8E1 framing. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data_o,
   output logic       receive_ack,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   rx_state_t            state, state_next;
   logic [CNT_W-1:0]     baud_cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bit;
   logic                 rxd_s, rxd_prev;
   logic                 samp_val, fall, tick_half, tick_bit, wrap, par_ok;

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxd_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // Vote over sample-1, sample, sample+1; the decision lands one cycle after the centre.
   localparam int START_LAST = CLKS_PER_BIT / 2;
   logic rxd_prev2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rxd_prev2 <= 1'b1;
      else     rxd_prev2 <= rxd_prev;
   end

   assign samp_val = (rxd_s & rxd_prev) | (rxd_s & rxd_prev2) | (rxd_prev & rxd_prev2);
`else
   localparam int START_LAST = CLKS_PER_BIT / 2 - 1;
   assign samp_val = rxd_s;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rxd_prev <= 1'b1;
      else     rxd_prev <= rxd_s;
   end

   assign fall      = rxd_prev & ~rxd_s;
   assign tick_half = (baud_cnt == CNT_W'(START_LAST));
   assign tick_bit  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign wrap      = (state == START) ? tick_half : tick_bit;
   assign par_ok    = (par_bit == (^shift ^ ~PARITY_EVEN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      unique case (state)
         IDLE:   if (fall) state_next = START;
         START:  if (tick_half) state_next = samp_val ? IDLE : DATA;
         DATA:   if (tick_bit && bit_idx == 3'(DATA_BITS - 1)) state_next = PARITY;
         PARITY: if (tick_bit) state_next = STOP;
         STOP:
            if (tick_bit) begin
               // A start edge coinciding with the stop decision is taken straight away.
               if (!samp_val) state_next = BREAK;
               else if (fall) state_next = START;
               else           state_next = IDLE;
            end
         BREAK:  if (rxd_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         par_bit     <= 1'b0;
         data_o      <= 8'h00;
         receive_ack <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         receive_ack <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;

         if (state == IDLE || state == BREAK || wrap) baud_cnt <= '0;
         else                                         baud_cnt <= baud_cnt + CNT_W'(1);

         if (state == START && tick_half) bit_idx <= '0;

         if (state == DATA && tick_bit) begin
            shift[bit_idx] <= samp_val;
            bit_idx        <= bit_idx + 3'd1;
         end

         if (state == PARITY && tick_bit) par_bit <= samp_val;

         if (state == STOP && tick_bit) begin
            if (!samp_val) begin
               frame_err <= 1'b1;
            end else if (par_ok) begin
               data_o      <= shift;
               receive_ack <= 1'b1;
            end else begin
               parity_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are modelled at byte level, pulses checked by a monitor.
module tb_uart_rx;

   localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   localparam int LAT = (21 * CPB) / 2 + 3 + MAJ;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] data_o;
   logic       receive_ack, parity_err, frame_err, busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst         (rst),
      .rxd         (rxd),
      .data_o      (data_o),
      .receive_ack (receive_ack),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;   // 0 receive_ack, 1 parity_err, 2 frame_err
      logic [7:0] data;   // data_o expected while the pulse is high
      int         start;  // cycle the start bit reached the line
   } exp_t;

   exp_t       q[$];
   logic [7:0] last_good = 8'h00;
   int         n_pass = 0;
   int         n_total = 0;

   task automatic check(input string name, input int act, input int exp, input int tol = 0);
      n_total++;
      if (act >= exp - tol && act <= exp + tol) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
   endtask

   // Monitor: every pulse must match the oldest expected frame outcome.
   exp_t m_e;
   int   m_kind;
   always @(negedge clk) begin
      if (!rst && (receive_ack || parity_err || frame_err)) begin
         check("pulse_exclusive", int'(receive_ack) + int'(parity_err) + int'(frame_err), 1);
         m_kind = receive_ack ? 0 : (parity_err ? 1 : 2);
         if (q.size() == 0) begin
            check("pulse_expected", q.size(), 1);
         end else begin
            m_e = q.pop_front();
            check("pulse_kind", m_kind, m_e.kind);
            check("data_o", int'(data_o), int'(m_e.data));
            check("latency", cyc - m_e.start, LAT, 1);
         end
      end
   end

   task automatic drive_bit(input logic v);
      rxd = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // spike: data bit index carrying a 1-cycle high pulse at its centre; abort_bit: reset there.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                             input int spike = -1, input int abort_bit = -1);
      logic [7:0] seen;
      exp_t       e;
      seen = d;
      if (MAJ == 0 && spike >= 0) seen[spike] = 1'b1;
      if (abort_bit < 0) begin
         e.start = cyc + 1;
         if (!stp) begin
            e.kind = 2;
            e.data = last_good;
         end else if (par == ^seen) begin
            e.kind    = 0;
            e.data    = seen;
            last_good = seen;
         end else begin
            e.kind = 1;
            e.data = last_good;
         end
         q.push_back(e);
      end
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == abort_bit) begin
            rxd = d[i];
            repeat (CPB / 2) @(negedge clk);
            rst = 1'b1;
            #1;
            check("rst_data_o", int'(data_o), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_pulses", int'(receive_ack | parity_err | frame_err), 0);
            repeat (3) @(negedge clk);
            rst       = 1'b0;
            rxd       = 1'b1;
            last_good = 8'h00;
            return;
         end else if (i == spike) begin
            rxd = d[i];
            repeat (CPB / 2) @(negedge clk);
            rxd = 1'b1;
            @(negedge clk);
            rxd = d[i];
            repeat (CPB / 2 - 1) @(negedge clk);
         end else begin
            drive_bit(d[i]);
         end
         if (i == 2) check("busy_mid_frame", int'(busy), 1);
      end
      drive_bit(par);
      drive_bit(stp);
   endtask

   initial begin
      logic [7:0] d;
      logic       par, stp;

      repeat (3) @(negedge clk);
      check("reset_data_o", int'(data_o), 0);
      check("reset_busy", int'(busy), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_busy", int'(busy), 0);

      send_frame(8'hA5, 1'b0, 1'b1);
      idle(CPB * 2);
      send_frame(8'h01, 1'b0, 1'b1);
      idle(CPB * 2);

      rxd = 1'b0;
      repeat (5) @(negedge clk);
      idle(CPB * 2);
      check("glitch_busy", int'(busy), 0);

      send_frame(8'h00, 1'b0, 1'b1, 3);
      idle(CPB * 2);

      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (40 * CPB) @(negedge clk);
      check("break_busy", int'(busy), 1);
      idle(4);
      check("break_exit_busy", int'(busy), 0);
      idle(CPB);
      send_frame(8'h7E, 1'b0, 1'b1);
      idle(CPB * 2);

      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      idle(CPB * 2);

      send_frame(8'hC3, 1'b0, 1'b1, -1, 4);
      idle(CPB * 2);
      send_frame(8'h5A, 1'b0, 1'b1);
      idle(CPB * 2);

      for (int n = 0; n < 12; n++) begin
         d   = 8'($urandom);
         par = (^d) ^ ($urandom_range(0, 3) == 0);
         stp = ($urandom_range(0, 5) != 0);
         send_frame(d, par, stp);
         if (!stp) idle(CPB);
         else      idle($urandom_range(0, 2) * (CPB / 2));
      end

      for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
      check("queue_drained", q.size(), 0);
      idle(CPB * 4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
